// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
//   Sits between the UART receiver and the flight-command decoder. It hunts
//   for SYNC_BYTE, collects a length-prefixed payload into a local buffer and
//   verifies an 8-bit additive checksum (LEN + payload, mod 256). Only frames
//   that check good are drained downstream over a valid/ready interface, so
//   the decoder only ever sees whole, checked frames.
//
//   Frame on the wire: SYNC_BYTE, LEN, PAYLOAD[LEN], CHK
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   rx_data/valid   received byte with a one-cycle strobe
//   out_data/valid  payload byte towards the decoder
//   out_ready       downstream accept (transfer = out_valid & out_ready)
//   out_last        final payload byte of the frame
//   frame_ok        pulse: checksum matched, drain begins
//   chk_err         pulse: checksum mismatch, frame dropped
//   len_err         pulse: LEN of 0 or above MAX_LEN, frame dropped
//   overrun         pulse per rx byte dropped while draining
//   timeout_err     pulse: partial frame aborted after inter-byte timeout
//   busy            parser is anywhere other than hunting for sync
//
// Configuration
//   PARSER_TIMEOUT_EN  when defined, a partial frame idle for TIMEOUT_CYC
//                      cycles (in LEN/PAY/CHK) is aborted. When undefined the
//                      parser waits forever and timeout_err is tied to 0.
// ---------------------------------------------------------------------------
module uart_frame_parser #(
    parameter int         ClkFrequency = 50000000,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CYC  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       chk_err,
    output logic       len_err,
    output logic       overrun,
    output logic       timeout_err,
    output logic       busy
);

    // Pointer width for the buffer index; kept at least 1 so MAX_LEN=1 works.
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    // Catch impossible configurations at elaboration time.
    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 1 || ClkFrequency < 1) begin : g_bad_params
        $error("uart_frame_parser: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAY,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] wr_ptr_q, wr_ptr_d;
    logic [7:0] rd_ptr_q, rd_ptr_d;
    logic       out_valid_q, out_valid_d;
    logic       frame_ok_q, frame_ok_d;
    logic       chk_err_q, chk_err_d;
    logic       len_err_q, len_err_d;
    logic       overrun_q, overrun_d;
    logic       timeout_err_q, timeout_err_d;

    // Payload storage; contents are don't-care after reset so no reset here.
    logic [7:0] buf_mem [2**AW];

`ifdef PARSER_TIMEOUT_EN
    localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        sum_d         = sum_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        out_valid_d   = out_valid_q;
        frame_ok_d    = 1'b0;
        chk_err_d     = 1'b0;
        len_err_d     = 1'b0;
        overrun_d     = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
                        len_d    = rx_data;
                        sum_d    = rx_data;
                        wr_ptr_d = 8'd0;
                        state_d  = S_PAY;
                    end else begin
                        // Bad length byte is consumed, not re-tried as sync.
                        len_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_PAY: begin
                if (rx_valid) begin
                    sum_d    = sum_q + rx_data;
                    wr_ptr_d = wr_ptr_q + 8'd1;
                    if (wr_ptr_q == len_q - 8'd1) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        frame_ok_d  = 1'b1;
                        out_valid_d = 1'b1;
                        rd_ptr_d    = 8'd0;
                        state_d     = S_DRAIN;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                // The buffer is busy being read out; incoming bytes are lost.
                overrun_d = rx_valid;
                if (out_valid_q && out_ready) begin
                    if (rd_ptr_q == len_q - 8'd1) begin
                        out_valid_d = 1'b0;
                        state_d     = S_HUNT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 8'd1;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

`ifdef PARSER_TIMEOUT_EN
        // Only a partially received frame is timed out; the counter restarts
        // on every byte and stays cleared in HUNT/DRAIN (so entering LEN
        // always starts from zero). A timeout needs a cycle without rx_valid,
        // so it can never coincide with another error pulse.
        to_cnt_d = '0;
        if (state_q == S_LEN || state_q == S_PAY || state_q == S_CHK) begin
            if (rx_valid) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                timeout_err_d = 1'b1;
                state_d       = S_HUNT;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_HUNT;
            len_q         <= 8'd0;
            sum_q         <= 8'd0;
            wr_ptr_q      <= 8'd0;
            rd_ptr_q      <= 8'd0;
            out_valid_q   <= 1'b0;
            frame_ok_q    <= 1'b0;
            chk_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            sum_q         <= sum_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            out_valid_q   <= out_valid_d;
            frame_ok_q    <= frame_ok_d;
            chk_err_q     <= chk_err_d;
            len_err_q     <= len_err_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
`ifdef PARSER_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_PAY && rx_valid) buf_mem[wr_ptr_q[AW-1:0]] <= rx_data;
    end

    // Data/last derive from flops only, so they stay stable under backpressure;
    // gated by out_valid so every output reads 0 in reset.
    assign out_valid   = out_valid_q;
    assign out_data    = out_valid_q ? buf_mem[rd_ptr_q[AW-1:0]] : 8'h00;
    assign out_last    = out_valid_q && (rd_ptr_q == len_q - 8'd1);
    assign frame_ok    = frame_ok_q;
    assign chk_err     = chk_err_q;
    assign len_err     = len_err_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

    localparam int TO_CYC = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid, out_last, frame_ok, chk_err, len_err, overrun, timeout_err, busy;

    int total = 0;
    int bad   = 0;

    // Event counters and transfer log filled by the negedge monitor.
    int         n_ok = 0, n_chk = 0, n_len = 0, n_ovr = 0, n_to = 0;
    logic [8:0] outq[$];

    uart_frame_parser #(
        .ClkFrequency(50000000),
        .SYNC_BYTE   (8'hA5),
        .MAX_LEN     (16),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_ok   (frame_ok),
        .chk_err    (chk_err),
        .len_err    (len_err),
        .overrun    (overrun),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            n_ok  += int'(frame_ok);
            n_chk += int'(chk_err);
            n_len += int'(len_err);
            n_ovr += int'(overrun);
            n_to  += int'(timeout_err);
            if (out_valid && out_ready) outq.push_back({out_last, out_data});
        end
    end

    // Byte is presented for exactly one rising edge; returns 1 ns after it.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_head_frame1();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10);
        send_byte(8'h20); send_byte(8'h30);
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 60 && outq.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, out_data, out_last, frame_ok, chk_err, len_err, overrun, timeout_err, busy} !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_data, out_last, frame_ok, chk_err, len_err, overrun, timeout_err, busy});
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_good_frame();
        int b0 = outq.size();
        int ok0 = n_ok;
        logic [8:0] exp [3];
        exp = '{9'h010, 9'h020, 9'h130};
        send_head_frame1();
        send_byte(8'h63);
        total++;
        if ({frame_ok, out_valid, out_data, out_last} !== 11'b11_0001_0000_0) begin
            bad++;
            $display("FAIL good_first_beat got ok=%b v=%b d=%h l=%b exp ok=1 v=1 d=10 l=0", frame_ok, out_valid, out_data, out_last);
        end
        wait_out(b0 + 3);
        @(negedge clk);
        total++;
        if (outq.size() !== b0 + 3) begin
            bad++;
            $display("FAIL good_count got=%0d exp=%0d", outq.size() - b0, 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (outq[b0+i] !== exp[i]) begin
                    bad++;
                    $display("FAIL good_byte%0d got=%h exp=%h", i, outq[b0+i], exp[i]);
                end
            end
        end
        total++;
        if ({out_valid, busy} !== 2'b00 || n_ok - ok0 !== 1) begin
            bad++;
            $display("FAIL good_end got v=%b busy=%b oks=%0d exp v=0 busy=0 oks=1", out_valid, busy, n_ok - ok0);
        end
    endtask

    task automatic test_bad_chk();
        int b0 = outq.size();
        send_head_frame1();
        send_byte(8'h64);
        total++;
        if ({chk_err, frame_ok, out_valid, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL badchk_pulse got chk=%b ok=%b v=%b busy=%b exp 1 0 0 0", chk_err, frame_ok, out_valid, busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (outq.size() !== b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL badchk_nodata got=%0d bytes v=%b exp 0 bytes v=0", outq.size() - b0, out_valid);
        end
        test_good_frame();
    endtask

    task automatic test_len_err();
        int b0 = outq.size();
        send_byte(8'hA5); send_byte(8'h00);
        total++;
        if ({len_err, busy} !== 2'b10) begin
            bad++;
            $display("FAIL len_zero got len_err=%b busy=%b exp 1 0", len_err, busy);
        end
        send_byte(8'hA5); send_byte(8'h11);
        total++;
        if ({len_err, busy} !== 2'b10) begin
            bad++;
            $display("FAIL len_big got len_err=%b busy=%b exp 1 0", len_err, busy);
        end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA6);
        total++;
        if ({frame_ok, out_valid, out_data, out_last} !== 11'b11_1010_0101_1) begin
            bad++;
            $display("FAIL len_one got ok=%b v=%b d=%h l=%b exp ok=1 v=1 d=a5 l=1", frame_ok, out_valid, out_data, out_last);
        end
        wait_out(b0 + 1);
        total++;
        if (outq.size() !== b0 + 1 || outq[b0] !== 9'h1A5) begin
            bad++;
            $display("FAIL len_one_xfer got n=%0d exp n=1 byte a5 last", outq.size() - b0);
        end
    endtask

    task automatic test_backpressure();
        int b0 = outq.size();
        int ov0 = n_ovr;
        int hold_bad = 0;
        logic [8:0] exp [3];
        exp = '{9'h010, 9'h020, 9'h130};
        out_ready = 1'b0;
        send_head_frame1();
        send_byte(8'h63);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({out_valid, out_data, out_last} !== 10'b1_0001_0000_0) hold_bad++;
        end
        send_byte(8'h55);
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({out_valid, out_data, out_last} !== 10'b1_0001_0000_0) hold_bad++;
        end
        total++;
        if (hold_bad !== 0) begin
            bad++;
            $display("FAIL bp_hold got %0d unstable cycles exp 0 (now v=%b d=%h)", hold_bad, out_valid, out_data);
        end
        total++;
        if (n_ovr - ov0 !== 2) begin
            bad++;
            $display("FAIL bp_overrun got=%0d exp=2", n_ovr - ov0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_out(b0 + 3);
        total++;
        if (outq.size() !== b0 + 3) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=3", outq.size() - b0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (outq[b0+i] !== exp[i]) begin
                    bad++;
                    $display("FAIL bp_byte%0d got=%h exp=%h", i, outq[b0+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int to0 = n_to;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        repeat (TO_CYC + 5) @(negedge clk);
`ifdef PARSER_TIMEOUT_EN
        total++;
        if (n_to - to0 !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_on got pulses=%0d busy=%b exp 1 0", n_to - to0, busy);
        end
`else
        total++;
        if (n_to - to0 !== 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_off got pulses=%0d busy=%b exp 0 1", n_to - to0, busy);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        int b0, ok0;
        logic [8:0] exp [3];
        exp = '{9'h010, 9'h020, 9'h130};
        // Reset while draining under backpressure.
        out_ready = 1'b0;
        send_head_frame1();
        send_byte(8'h63);
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_data, busy} !== 10'h0) begin
            bad++;
            $display("FAIL rst_drain got v=%b d=%h busy=%b exp 0", out_valid, out_data, busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        // Reset mid-payload.
        b0  = outq.size();
        ok0 = n_ok;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10);
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_data, out_last, frame_ok, chk_err, len_err, overrun, timeout_err, busy} !== 16'h0) begin
            bad++;
            $display("FAIL rst_mid got=%h exp=0", {out_valid, out_data, out_last, frame_ok, chk_err, len_err, overrun, timeout_err, busy});
        end
        @(posedge clk); #1 rst = 1'b0;
        send_head_frame1();
        send_byte(8'h63);
        wait_out(b0 + 3);
        repeat (2) @(negedge clk);
        total++;
        if (n_ok - ok0 !== 1 || outq.size() !== b0 + 3) begin
            bad++;
            $display("FAIL rst_recover got oks=%0d bytes=%0d exp 1 3", n_ok - ok0, outq.size() - b0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (outq[b0+i] !== exp[i]) begin
                    bad++;
                    $display("FAIL rst_byte%0d got=%h exp=%h", i, outq[b0+i], exp[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_len_err();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
